// File: rtl/johnson_decoder_pkg.sv
// Shared definitions for the Johnson-code decoder/monitor.
//   johnson_code()  : expected bit pattern for a step index of a W-bit Johnson counter
//   lock_state_e    : lock FSM states
//   ERR_MAX         : saturation value of the error counter
package johnson_pkg;

  localparam int ERR_MAX = 255;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_e;

  // The first half of the sequence fills with ones from the LSB.
  // The second half clears ones from the LSB, starting at index w.
  function automatic logic [31:0] johnson_code(input int idx, input int w);
    logic [31:0] all_ones;
    all_ones = (32'd1 << w) - 32'd1;
    if (idx <= w) begin
      return (32'd1 << idx) - 32'd1;
    end
    return all_ones & ~((32'd1 << (idx - w)) - 32'd1);
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson-code source and the decoder/monitor.
//   master : drives code_in/code_valid, observes the decoder results
//   slave  : the decoder; samples the code, drives index/status/error count
interface johnson_decoder_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] code_in;
  logic             code_valid;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic             code_legal;
  logic             seq_error;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output code_in, code_valid,
    input  index, index_valid, code_legal, seq_error, locked, err_count
  );

  modport slave (
    input  code_in, code_valid,
    output index, index_valid, code_legal, seq_error, locked, err_count
  );

endinterface

// File: rtl/johnson_decoder_code_check.sv
// Combinational Johnson-code decoder.
//   code_i  : WIDTH-bit code
//   index_o : step index derived from popcount and MSB
//   legal_o : code matches the canonical pattern for index_o
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic [IW-1:0]    index_o,
  output logic             legal_o
);

  int          pop;
  int          idx;
  logic [31:0] pattern;

  always_comb begin
    pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (code_i[i]) pop = pop + 1;
    end
    // MSB set means we are in the draining half of the sequence.
    idx     = code_i[WIDTH-1] ? (2 * WIDTH - pop) : pop;
    pattern = johnson_code(idx, WIDTH);
    index_o = IW'(idx);
    legal_o = (pattern[WIDTH-1:0] == code_i);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-counter bus monitor: decodes each valid code, checks it advances by
// one step, tracks lock and counts errors seen while locked.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of johnson_decoder_if
//
// state   | meaning
// ACQUIRE | counting consecutive good samples toward LOCK_COUNT, no errors raised
// LOCKED  | stream trusted; any bad sample pulses seq_error and drops to ACQUIRE
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ALLOW_HOLD = 0
) (
  input  logic          clk,
  input  logic          reset,
  johnson_decoder_if.slave bus
);

  localparam int IW      = $clog2(2 * WIDTH);
  localparam int SEQ_LEN = 2 * WIDTH;
  localparam logic [3:0] RUN_LOCK = 4'(LOCK_COUNT);

  logic [IW-1:0] chk_index;
  logic          chk_legal;

  lock_state_e   state_q;
  logic [3:0]    run_q;
  logic [IW-1:0] prev_q;
  logic [IW-1:0] index_q;
  logic          index_valid_q;
  logic          code_legal_q;
  logic          seq_error_q;
  logic          locked_q;
  logic [7:0]    err_count_q;

  logic [IW-1:0] step_d;
  logic [3:0]    run_d;
  logic [7:0]    err_count_d;
  logic          good_d;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code_i  (bus.code_in),
    .index_o (chk_index),
    .legal_o (chk_legal)
  );

  always_comb begin
    step_d      = (prev_q == IW'(SEQ_LEN - 1)) ? '0 : prev_q + 1'b1;
    run_d       = (run_q == RUN_LOCK) ? run_q : run_q + 4'd1;
    err_count_d = (err_count_q == 8'(ERR_MAX)) ? err_count_q : err_count_q + 8'd1;
    // With no run yet there is no reference, so any legal code starts one.
    good_d      = chk_legal &&
                  ((run_q == 4'd0) ||
                   (chk_index == step_d) ||
                   ((ALLOW_HOLD != 0) && (chk_index == prev_q)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACQUIRE;
      run_q         <= '0;
      prev_q        <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      code_legal_q  <= 1'b0;
      seq_error_q   <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      index_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      if (bus.code_valid) begin
        index_valid_q <= chk_legal;
        code_legal_q  <= chk_legal;
        if (chk_legal) index_q <= chk_index;
        case (state_q)
          ACQUIRE: begin
            if (good_d) begin
              run_q  <= run_d;
              prev_q <= chk_index;
              if (run_d == RUN_LOCK) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else if (chk_legal) begin
              // Wrong step but a valid code: restart the run from here.
              run_q  <= 4'd1;
              prev_q <= chk_index;
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (good_d) begin
              prev_q <= chk_index;
            end else begin
              seq_error_q <= 1'b1;
              err_count_q <= err_count_d;
              locked_q    <= 1'b0;
              state_q     <= ACQUIRE;
              if (chk_legal) begin
                run_q  <= 4'd1;
                prev_q <= chk_index;
              end else begin
                run_q <= '0;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.code_legal  = code_legal_q;
  assign bus.seq_error   = seq_error_q;
  assign bus.locked      = locked_q;
  assign bus.err_count   = err_count_q;

endmodule
